// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked
// shift of 8 data bits + odd parity + stop, then ack check. Top level owns the tristates.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int START_CYCLES   = 650,
  parameter int LOG_TIMEOUT    = 21
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out,
  output logic [1:0] err_code_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe_out,
  output logic       ps2_data_oe_out
);

  localparam int TMAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall, watch, timeout, accept;
  logic clk_oe, data_oe, done, err;
  logic [TW-1:0]          timer_q;
  logic [LOG_TIMEOUT-1:0] wd_q;
  logic [3:0]             bit_cnt_q;
  logic [8:0]             shift_q;
  logic                   data_bit_q;
  logic [1:0]             err_code_q, err_code_d;

  // Synchronizers reset to the idle (released, high) line level so no false fall
  // is seen after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the 2-flop chain a real pipeline.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign watch   = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign timeout = watch && (wd_q == '1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every signal is given a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clk_oe     = 1'b0;
    data_oe    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    err_code_d = 2'b00;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          accept  = 1'b1;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe = 1'b1;
        if (timer_q == INH_LAST) state_d = S_START;
      end
      S_START: begin
        clk_oe  = 1'b1;
        data_oe = 1'b1;
        if (timer_q == START_LAST) state_d = S_SEND;
      end
      S_SEND: begin
        data_oe = data_bit_q;
        if (fall && bit_cnt_q == 4'd9) state_d = S_ACK;
      end
      S_ACK: begin
        if (fall) begin
          if (data_sync_q) begin
            err        = 1'b1;
            err_code_d = 2'b10;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A line that has gone quiet too long aborts the transfer and releases both
    // lines in the same cycle; a completed handshake still wins.
    if (timeout && !done) begin
      err        = 1'b1;
      err_code_d = 2'b01;
      clk_oe     = 1'b0;
      data_oe    = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer_q    <= '0;
      wd_q       <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_bit_q <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      timer_q <= ((state_q == S_INHIBIT || state_q == S_START) && state_d == state_q)
                 ? timer_q + 1'b1 : '0;
      wd_q    <= (watch && state_d == state_q && !fall) ? wd_q + 1'b1 : '0;
      if (accept) begin
        shift_q    <= {~^data_in, data_in};
        bit_cnt_q  <= '0;
        data_bit_q <= 1'b1;
        err_code_q <= 2'b00;
      end else if (state_q == S_SEND && fall) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (bit_cnt_q < 4'd9) begin
          data_bit_q <= ~shift_q[0];
          shift_q    <= {1'b0, shift_q[8:1]};
        end else begin
          data_bit_q <= 1'b0;
        end
      end
      if (err) err_code_q <= err_code_d;
    end
  end

  assign ready_out       = (state_q == S_IDLE);
  assign busy_out        = ~ready_out;
  assign done_out        = done;
  assign err_out         = err;
  assign err_code_out    = err ? err_code_d : err_code_q;
  assign ps2_clk_oe_out  = clk_oe;
  assign ps2_data_oe_out = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model on open-drain lines,
// table-driven frames plus hand-written reset, timeout and held-request sequences.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int ST   = 10;
  localparam int LOGT = 7;
  localparam int HALF = 12;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, busy_out, done_out, err_out;
  logic [1:0] err_code_out;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe_out, ps2_data_oe_out;
  logic       dev_clk, dev_data;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe_out;
  assign ps2_data_in = dev_data & ~ps2_data_oe_out;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(ST), .LOG_TIMEOUT(LOGT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
    .err_code_out(err_code_out), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe_out(ps2_clk_oe_out), .ps2_data_oe_out(ps2_data_oe_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int acc_cnt  = 0;
  bit both_seen = 1'b0;
  bit oe_at_pulse_bad = 1'b0;

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (done_out) done_cnt++;
      if (err_out) err_cnt++;
      if (done_out && err_out) both_seen = 1'b1;
      if ((done_out || err_out) && (ps2_clk_oe_out || ps2_data_oe_out)) oe_at_pulse_bad = 1'b1;
    end
  end

  always @(posedge clk_in) begin
    if (rst_n_in && valid_in && ready_out) acc_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [7:0] d);
    @(negedge clk_in);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Measures the inhibit/start phases, then acts as the device for nfalls clocks,
  // capturing the line data at each rising edge (device sampling point).
  task automatic run_frame(input int nfalls, input bit ack, output int inh, output int st,
                           output logic [9:0] frame);
    int g;
    inh = 0; st = 0; frame = '0; g = 0;
    while (!ps2_clk_oe_out && g < 50) begin @(negedge clk_in); g++; end
    while (ps2_clk_oe_out && !ps2_data_oe_out && inh < 4 * INH) begin inh++; @(negedge clk_in); end
    while (ps2_clk_oe_out && ps2_data_oe_out && st < 4 * ST) begin st++; @(negedge clk_in); end
    for (int i = 1; i <= nfalls; i++) begin
      repeat (HALF) @(negedge clk_in);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_in);
      if (i <= 10) frame[i-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int base, output bit seen);
    seen = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (done_cnt + err_cnt > base) begin seen = 1'b1; break; end
      @(negedge clk_in); #1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] frame;
    int         done_d;
    int         err_d;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int inh, st, base, base_d, base_e, acc0, n;
    logic [9:0] frame;
    bit seen;

    vecs[0] = '{8'hF4, 1'b1, 10'h2F4, 1, 0, 2'b00};
    vecs[1] = '{8'hFF, 1'b0, 10'h3FF, 0, 1, 2'b10};
    vecs[2] = '{8'h00, 1'b1, 10'h300, 1, 0, 2'b00};
    vecs[3] = '{8'h01, 1'b1, 10'h201, 1, 0, 2'b00};
    vecs[4] = '{8'hA5, 1'b1, 10'h3A5, 1, 0, 2'b00};

    rst_n_in = 1'b0; valid_in = 1'b0; data_in = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_clk_oe", ps2_clk_oe_out, 0);
    check("rst_data_oe", ps2_data_oe_out, 0);
    check("rst_done", done_out, 0);
    check("rst_err", err_out, 0);
    check("rst_err_code", err_code_out, 0);
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    for (int i = 0; i < 5; i++) begin
      base_d = done_cnt; base_e = err_cnt; base = base_d + base_e;
      drive_req(vecs[i].data);
      run_frame(11, vecs[i].ack, inh, st, frame);
      wait_pulse(base, seen);
      check($sformatf("v%0d_pulse_seen", i), seen, 1);
      repeat (5) @(negedge clk_in); #1;
      check($sformatf("v%0d_inhibit_len", i), inh, INH);
      check($sformatf("v%0d_start_len", i), st, ST);
      check($sformatf("v%0d_frame", i), frame, vecs[i].frame);
      check($sformatf("v%0d_done_pulses", i), done_cnt - base_d, vecs[i].done_d);
      check($sformatf("v%0d_err_pulses", i), err_cnt - base_e, vecs[i].err_d);
      check($sformatf("v%0d_err_code", i), err_code_out, vecs[i].code);
      check($sformatf("v%0d_ready", i), ready_out, 1);
    end

    // Device never clocks: watchdog fires after 2**LOGT-1 quiet cycles.
    drive_req(8'hF4);
    run_frame(0, 1'b0, inh, st, frame);
    n = 0;
    while (!err_out && n < 1000) begin @(negedge clk_in); n++; end
    check("to_cycles", n, (1 << LOGT) - 1);
    check("to_err_code", err_code_out, 2'b01);
    check("to_oe", {ps2_clk_oe_out, ps2_data_oe_out}, 2'b00);
    check("to_done_low", done_out, 0);
    @(negedge clk_in);
    check("to_ready_after", ready_out, 1);
    check("to_code_hold", err_code_out, 2'b01);

    // Asynchronous reset after the fourth device clock.
    base_d = done_cnt; base_e = err_cnt;
    drive_req(8'hF4);
    run_frame(4, 1'b0, inh, st, frame);
    check("mid_frame_bits", frame[3:0], 4'h4);
    check("mid_data_oe_pre", ps2_data_oe_out, 1);
    #1 rst_n_in = 1'b0;
    #1;
    check("mid_rst_oe", {ps2_clk_oe_out, ps2_data_oe_out}, 2'b00);
    check("mid_rst_ready", ready_out, 1);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in); #1;
    check("mid_ready_after", ready_out, 1);
    check("mid_no_pulse", (done_cnt - base_d) + (err_cnt - base_e), 0);

    // valid_in held high: one accept per transfer, next one right after done.
    base_d = done_cnt; acc0 = acc_cnt;
    @(negedge clk_in);
    data_in = 8'h01; valid_in = 1'b1;
    run_frame(11, 1'b1, inh, st, frame);
    check("held_frame", frame, 10'h201);
    n = 0;
    while (!done_out && n < 200) begin @(negedge clk_in); n++; end
    check("held_done", done_out, 1);
    check("held_one_accept", acc_cnt - acc0, 1);
    check("held_busy_at_done", ready_out, 0);
    @(negedge clk_in);
    check("held_ready_back", ready_out, 1);
    check("held_still_one", acc_cnt - acc0, 1);
    @(negedge clk_in);
    check("held_second_accept", acc_cnt - acc0, 2);
    check("held_inhibit_again", ps2_clk_oe_out, 1);
    valid_in = 1'b0;
    base = done_cnt + err_cnt;
    run_frame(11, 1'b1, inh, st, frame);
    wait_pulse(base, seen);
    check("held2_inhibit_len", inh, INH);
    check("held2_frame", frame, 10'h201);
    check("held2_done", done_cnt - base_d, 2);
    repeat (5) @(negedge clk_in); #1;
    check("held_total_accepts", acc_cnt - acc0, 2);

    check("never_done_and_err", both_seen, 0);
    check("oe_released_at_pulse", oe_at_pulse_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
